// File: rtl/msrh_l1d_wr_arbiter.sv
// L1D write-port arbiter.
// Shares the single L1D data-array write port between REQ_NUM requesters
// (0: LRQ refill, 1: store-buffer write, 2: store-buffer merge).
// Selection is fixed-priority, lowest index first. A requester that has been
// denied STARVE_TH cycles in a row overrides that priority. The winner is
// registered into a one-entry issue slot, which drives the L1D write port and
// replays its write while the L1D reports a conflict.
module msrh_l1d_wr_arbiter #(
  parameter int unsigned REQ_NUM   = 3,
  parameter int unsigned PADDR_W   = 56,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned STARVE_TH = 8
) (
  input  logic                                i_clk,
  input  logic                                i_reset_n,

  input  logic [REQ_NUM-1:0]                  i_req_valid,
  input  logic [REQ_NUM-1:0][PADDR_W-1:0]     i_req_paddr,
  input  logic [REQ_NUM-1:0][DATA_W-1:0]      i_req_data,
  input  logic [REQ_NUM-1:0][DATA_W/8-1:0]    i_req_be,
  output logic [REQ_NUM-1:0]                  o_req_accept,

  output logic                                o_wr_valid,
  output logic [PADDR_W-1:0]                  o_wr_paddr,
  output logic [DATA_W-1:0]                   o_wr_data,
  output logic [DATA_W/8-1:0]                 o_wr_be,
  input  logic                                i_wr_conflict,

  output logic                                o_starve_active
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_TH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_TH);

  // Issue slot
  logic               r_valid;
  logic [PADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0]  r_data;
  logic [BE_W-1:0]    r_be;

  // Per-requester consecutive-denial counters
  logic [CNT_W-1:0]   r_starve_cnt [REQ_NUM];

  logic               w_slot_free;
  logic [REQ_NUM-1:0] w_starve_hit;
  logic [REQ_NUM-1:0] w_starve_oh;
  logic [REQ_NUM-1:0] w_prio_oh;
  logic [REQ_NUM-1:0] w_win_oh;
  logic               w_accept_any;
  logic [PADDR_W-1:0] w_sel_paddr;
  logic [DATA_W-1:0]  w_sel_data;
  logic [BE_W-1:0]    w_sel_be;

  // The slot can take a new write when it is empty, or when its write completes this cycle.
  // Conflict only matters while the slot holds a write.
  assign w_slot_free = !r_valid || !i_wr_conflict;

  // Find starving requesters and select the lowest-index starving and the lowest-index valid requester.
  always_comb begin
    logic found_starve;
    logic found_prio;
    w_starve_hit = '0;
    w_starve_oh  = '0;
    w_prio_oh    = '0;
    found_starve = 1'b0;
    found_prio   = 1'b0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      w_starve_hit[i] = i_req_valid[i] && (r_starve_cnt[i] == CNT_MAX);
      if (!found_starve && w_starve_hit[i]) begin
        w_starve_oh[i] = 1'b1;
        found_starve   = 1'b1;
      end
      if (!found_prio && i_req_valid[i]) begin
        w_prio_oh[i] = 1'b1;
        found_prio   = 1'b1;
      end
    end
  end

  // A starving requester takes precedence over the base priority order.
  // Accept is gated by slot availability, so it cannot coincide with a conflict replay.
  always_comb begin
    w_win_oh        = (|w_starve_hit) ? w_starve_oh : w_prio_oh;
    o_req_accept    = w_slot_free ? w_win_oh : '0;
    w_accept_any    = |o_req_accept;
    o_starve_active = |w_starve_hit;
  end

  // AND-OR mux of the winning requester's payload (the winner is one-hot).
  always_comb begin
    w_sel_paddr = '0;
    w_sel_data  = '0;
    w_sel_be    = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (w_win_oh[i]) begin
        w_sel_paddr = w_sel_paddr | i_req_paddr[i];
        w_sel_data  = w_sel_data  | i_req_data[i];
        w_sel_be    = w_sel_be    | i_req_be[i];
      end
    end
  end

  // Issue slot: capture on accept, drain when the write completes, hold while the L1D rejects it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_paddr <= '0;
      r_data  <= '0;
      r_be    <= '0;
    end else if (w_accept_any) begin
      r_valid <= 1'b1;
      r_paddr <= w_sel_paddr;
      r_data  <= w_sel_data;
      r_be    <= w_sel_be;
    end else if (w_slot_free) begin
      r_valid <= 1'b0;
    end
  end

  // Denial counters: count up to saturation while waiting; clear on accept or when the request drops.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
        r_starve_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
        if (!i_req_valid[i] || o_req_accept[i]) begin
          r_starve_cnt[i] <= '0;
        end else if (r_starve_cnt[i] != CNT_MAX) begin
          r_starve_cnt[i] <= r_starve_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_wr_valid = r_valid;
  assign o_wr_paddr = r_paddr;
  assign o_wr_data  = r_data;
  assign o_wr_be    = r_be;

endmodule

// File: tb/tb_msrh_l1d_wr_arbiter.sv
// Self-checking bench for msrh_l1d_wr_arbiter.
// Each per-cycle vector gives the request and conflict inputs with the expected accept and
// starve flags. A scoreboard queue holds the writes expected on the L1D port.
module tb_msrh_l1d_wr_arbiter;

  localparam int unsigned REQ_NUM = 3;
  localparam int unsigned PADDR_W = 56;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned BE_W    = DATA_W / 8;

  logic                             clk;
  logic                             rst_n;
  logic [REQ_NUM-1:0]               req_valid;
  logic [REQ_NUM-1:0][PADDR_W-1:0]  req_paddr;
  logic [REQ_NUM-1:0][DATA_W-1:0]   req_data;
  logic [REQ_NUM-1:0][BE_W-1:0]     req_be;
  logic [REQ_NUM-1:0]               req_accept;
  logic                             wr_valid;
  logic [PADDR_W-1:0]               wr_paddr;
  logic [DATA_W-1:0]                wr_data;
  logic [BE_W-1:0]                  wr_be;
  logic                             wr_conflict;
  logic                             starve_active;

  msrh_l1d_wr_arbiter #(
    .REQ_NUM   (REQ_NUM),
    .PADDR_W   (PADDR_W),
    .DATA_W    (DATA_W),
    .STARVE_TH (8)
  ) u_dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_req_valid     (req_valid),
    .i_req_paddr     (req_paddr),
    .i_req_data      (req_data),
    .i_req_be        (req_be),
    .o_req_accept    (req_accept),
    .o_wr_valid      (wr_valid),
    .o_wr_paddr      (wr_paddr),
    .o_wr_data       (wr_data),
    .o_wr_be         (wr_be),
    .i_wr_conflict   (wr_conflict),
    .o_starve_active (starve_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] valid;
    logic       conf;
    logic [2:0] acc;
    logic       st;
  } vec_t;

  typedef struct {
    logic [PADDR_W-1:0] paddr;
    logic [DATA_W-1:0]  data;
    logic [BE_W-1:0]    be;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  wr_t  cur [REQ_NUM];
  int   seq [REQ_NUM];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [2:0] valid, input logic conf,
                              input logic [2:0] acc, input logic st);
    vec_t v;
    v.valid = valid;
    v.conf  = conf;
    v.acc   = acc;
    v.st    = st;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // New payload for requester i, held stable until it is accepted.
  task automatic regen(input int i);
    seq[i]++;
    cur[i].paddr = PADDR_W'(64'h8000_0040 + (64'(i) << 24) + (64'(seq[i]) << 12));
    cur[i].data  = {$urandom, $urandom, $urandom, $urandom};
    cur[i].be    = BE_W'($urandom);
  endtask

  task automatic drive_payloads();
    for (int i = 0; i < REQ_NUM; i++) begin
      req_paddr[i] = cur[i].paddr;
      req_data[i]  = cur[i].data;
      req_be[i]    = cur[i].be;
    end
  endtask

  // Apply one vector cycle: drive just after posedge, check at negedge, then update the scoreboard.
  task automatic apply(input vec_t v, input int id);
    req_valid   = v.valid;
    wr_conflict = v.conf;
    drive_payloads();
    @(negedge clk);
    if (sb.size() > 0) begin
      chk("wr_valid", id, DATA_W'(wr_valid), DATA_W'(1));
      chk("wr_paddr", id, DATA_W'(wr_paddr), DATA_W'(sb[0].paddr));
      chk("wr_data",  id, wr_data, sb[0].data);
      chk("wr_be",    id, DATA_W'(wr_be), DATA_W'(sb[0].be));
    end else begin
      chk("wr_valid", id, DATA_W'(wr_valid), DATA_W'(0));
    end
    chk("accept", id, DATA_W'(req_accept), DATA_W'(v.acc));
    chk("starve", id, DATA_W'(starve_active), DATA_W'(v.st));
    if (sb.size() > 0 && !v.conf) void'(sb.pop_front());
    for (int i = 0; i < REQ_NUM; i++) begin
      if (v.acc[i]) begin
        sb.push_back(cur[i]);
        regen(i);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int id;
    for (int i = 0; i < REQ_NUM; i++) begin
      seq[i] = -1;
      regen(i);
    end
    cur[1].paddr = PADDR_W'(64'h8000_0040);
    cur[1].be    = BE_W'(16'hFF00);

    // Single request, then two idle cycles
    vecs.push_back(mk(3'b010, 1'b0, 3'b010, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));
    // Priority: req0 before req2, consecutive writes
    vecs.push_back(mk(3'b101, 1'b0, 3'b001, 1'b0));
    vecs.push_back(mk(3'b100, 1'b0, 3'b100, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));
    // Conflict with an empty slot is ignored
    vecs.push_back(mk(3'b000, 1'b1, 3'b000, 1'b0));
    // Conflict hold: 3 conflict cycles with req1 pending, accepted in the first clean cycle
    vecs.push_back(mk(3'b001, 1'b1, 3'b001, 1'b0));
    vecs.push_back(mk(3'b010, 1'b1, 3'b000, 1'b0));
    vecs.push_back(mk(3'b010, 1'b1, 3'b000, 1'b0));
    vecs.push_back(mk(3'b010, 1'b1, 3'b000, 1'b0));
    vecs.push_back(mk(3'b010, 1'b0, 3'b010, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));
    // Starvation: req0 wins 8 cycles, req1 forced in on the 9th, then req0 again
    for (int k = 0; k < 8; k++) vecs.push_back(mk(3'b011, 1'b0, 3'b001, 1'b0));
    vecs.push_back(mk(3'b011, 1'b0, 3'b010, 1'b1));
    vecs.push_back(mk(3'b011, 1'b0, 3'b001, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));
    // Counter clear: req2 denied 5, drops for 1, then needs a full 8 denials again
    for (int k = 0; k < 5; k++) vecs.push_back(mk(3'b101, 1'b0, 3'b001, 1'b0));
    vecs.push_back(mk(3'b001, 1'b0, 3'b001, 1'b0));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(3'b101, 1'b0, 3'b001, 1'b0));
    vecs.push_back(mk(3'b101, 1'b0, 3'b100, 1'b1));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));
    vecs.push_back(mk(3'b000, 1'b0, 3'b000, 1'b0));

    // Reset state
    rst_n       = 1'b0;
    req_valid   = '0;
    wr_conflict = 1'b0;
    drive_payloads();
    #12;
    chk("rst_wr_valid", 0, DATA_W'(wr_valid), DATA_W'(0));
    chk("rst_wr_paddr", 0, DATA_W'(wr_paddr), DATA_W'(0));
    chk("rst_wr_data",  0, wr_data, '0);
    chk("rst_wr_be",    0, DATA_W'(wr_be), DATA_W'(0));
    chk("rst_accept",   0, DATA_W'(req_accept), DATA_W'(0));
    chk("rst_starve",   0, DATA_W'(starve_active), DATA_W'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

    // Reset mid-conflict: slot held under conflict while req1 builds up denials
    id = 1000;
    apply(mk(3'b001, 1'b0, 3'b001, 1'b0), id++);
    for (int k = 0; k < 6; k++) apply(mk(3'b010, 1'b1, 3'b000, 1'b0), id++);
    req_valid   = 3'b010;
    wr_conflict = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_valid", id, DATA_W'(wr_valid), DATA_W'(0));
    chk("midrst_wr_paddr", id, DATA_W'(wr_paddr), DATA_W'(0));
    req_valid   = '0;
    wr_conflict = 1'b0;
    #1;
    chk("midrst_accept", id, DATA_W'(req_accept), DATA_W'(0));
    chk("midrst_starve", id, DATA_W'(starve_active), DATA_W'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Counters must have restarted from 0: req1 needs a full 8 denials before overriding
    id = 2000;
    for (int k = 0; k < 8; k++) apply(mk(3'b011, 1'b0, 3'b001, 1'b0), id++);
    apply(mk(3'b011, 1'b0, 3'b010, 1'b1), id++);
    apply(mk(3'b000, 1'b0, 3'b000, 1'b0), id++);
    apply(mk(3'b000, 1'b0, 3'b000, 1'b0), id++);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrh_l1d_wr_arbiter.md
# msrh_l1d_wr_arbiter

Single-port L1D write arbiter that shares the one L1D data-array write port between REQ_NUM write requesters. Default order: index 0 = LRQ refill, 1 = store-buffer write, 2 = store-buffer merge. Selection is fixed-priority with a per-requester starvation override. The winner is registered into a one-entry issue slot that drives the L1D write port and is held and replayed while the L1D reports a write conflict.

## Interface
Parameters:
- REQ_NUM, 3, number of write requesters; index 0 has highest base priority
- PADDR_W, riscv_pkg::PADDR_W, physical address width
- DATA_W, msrh_conf_pkg::DCACHE_DATA_W, L1D write data width; byte-enable width is DATA_W/8
- STARVE_TH, 8, denied-cycle count that forces a starving requester to win

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_req_valid  in  REQ_NUM  per-requester write request
- i_req_paddr  in  REQ_NUM x PADDR_W  per-requester line address
- i_req_data  in  REQ_NUM x DATA_W  per-requester write data
- i_req_be  in  REQ_NUM x DATA_W/8  per-requester byte enables
- o_req_accept  out  REQ_NUM  one-hot or zero; requester i is captured at the next edge
- o_wr_valid  out  1  L1D write request (registered)
- o_wr_paddr  out  PADDR_W  L1D write address (registered)
- o_wr_data  out  DATA_W  L1D write data (registered)
- o_wr_be  out  DATA_W/8  L1D byte enables (registered)
- i_wr_conflict  in  1  L1D rejected the write in this o_wr_valid cycle
- o_starve_active  out  1  a starvation override picked the current winner (debug/perf)

## Operation
- Issue slot: r_valid plus payload registers; these drive the o_wr_* ports directly.
- slot_free = !r_valid | (r_valid & !i_wr_conflict).
- Winner selection, combinational:
  - If any requester has valid & starve_cnt == STARVE_TH, the lowest such index wins and o_starve_active = 1.
  - Otherwise the lowest valid index wins.
- o_req_accept[i] = slot_free & (i is the winner). It is all-zero when slot_free = 0 or no request is valid.
- Edge update:
  - Accept: capture the winner's paddr/data/be and set r_valid = 1.
  - Else if slot_free: r_valid = 0.
  - Else (conflict): hold all slot registers unchanged, replaying the same write next cycle.
- Starvation counter per requester, width $clog2(STARVE_TH+1):
  - +1, saturating at STARVE_TH, when valid & !accept.
  - Cleared to 0 on accept or when valid = 0.
- Requester contract: payload must stay stable while valid & !accept. The arbiter never drops an accepted write.
- Conflict loop:
  - No retry limit; a write is held indefinitely under repeated conflict.
  - Starvation counters of waiting requesters keep incrementing meanwhile.
- Simultaneous accept and conflict cannot occur, because accept requires slot_free.

## Timing
- Reset (async assert, synchronous-safe deassert):
  - r_valid = 0, o_wr_valid = 0.
  - o_wr_paddr/data/be = 0.
  - All starve_cnt = 0.
  - o_req_accept = 0 and o_starve_active = 0 while no request is valid.
- Latency: request valid in cycle N with a free slot gives o_req_accept in N and o_wr_valid with its payload in N+1.
- Throughput: one write per cycle with back-to-back accepts when i_wr_conflict stays 0.
- Conflict:
  - o_wr_valid is held with an identical payload in N+2, N+3, … until the first cycle with i_wr_conflict = 0.
  - A new accept is possible in that same non-conflict cycle.
- Reset mid-operation: an in-flight slot is discarded, and o_wr_valid = 0 from reset assertion onward.
- i_wr_conflict is ignored when r_valid = 0.

## Test plan
- Single request: req1 valid for one cycle, paddr=0x8000_0040, be=0xFF<<8 → accept[1]=1 in cycle 0; o_wr_valid=1 in cycle 1 with the same paddr/be; o_wr_valid=0 in cycle 2.
- Priority: req0 and req2 valid in the same cycle → accept=3'b001; req2 is accepted the next cycle; the writes issue in consecutive cycles, paddr order req0 then req2.
- Conflict hold: slot valid, i_wr_conflict=1 for 3 cycles, req1 pending:
  - o_wr_valid stays 1 with unchanged payload for 4 cycles and accept=0 throughout.
  - In the first non-conflict cycle accept[1]=1, and the req1 write issues in the following cycle.
- Starvation (STARVE_TH=8): req0 and req1 continuously valid, req0 re-presenting each cycle:
  - req0 wins cycles 0–7; starve_cnt[1] reaches 8 at the end of cycle 7.
  - Cycle 8: accept=3'b010 and o_starve_active=1.
  - Cycle 9: starve_cnt[1]=0 and req0 wins again.
- Counter clear: req2 denied 5 cycles, then deasserted for 1 cycle → starve_cnt[2]=0; on reassertion it counts from 0.
- Reset mid-conflict: i_reset_n low while o_wr_valid=1 and i_wr_conflict=1 → o_wr_valid=0 immediately and all counters 0; after release, the first request is accepted in 1 cycle.
